instr_issue_queue: RTL
======================

# instr_issue_queue

Buffers 16-bit instructions ahead of the FSM controller and issues them one at a time with the controller's `s`/`w` start/wait handshake. It holds the executing instruction in a stable instruction register and decodes it into the fields the controller and datapath consume: `opcode`, `op`, sign-extended immediates, `shift`, and register numbers muxed by `nsel`. It sits directly upstream of the FSM controller and beside the register file's read/write address ports.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: producer has an instruction on `in_instr`.
- `in_instr` input 16: instruction word.
- `in_ready` output 1: queue can accept a word this cycle; `!full`.
- `w` input 1: controller is in WAIT (registered by the controller).
- `nsel` input 3: one-hot register select from the controller: Rn=3'b100, Rd=3'b010, Rm=3'b001.
- `s` output 1: start request to the controller.
- `opcode` output 3: `ir[15:13]`.
- `op` output 2: `ir[12:11]`.
- `shift` output 2: `ir[4:3]`.
- `sximm8` output 16: `ir[7:0]` sign-extended.
- `sximm5` output 16: `ir[4:0]` sign-extended.
- `readnum` output 3: register number selected by `nsel`.
- `writenum` output 3: same value as `readnum`.
- `busy` output 1: an instruction is launched or executing.
- `empty` output 1: queue holds no entries.
- `issued` output 8: count of instructions accepted by the controller; wraps at 255→0.

## Operation
- Queue: circular buffer of `DEPTH` × 16 bits, with `log2(DEPTH)+1`-bit read and write pointers.
  - Push when `in_valid && in_ready`.
  - Pop only on issue, described below.
- Full and empty:
  - `in_ready` deasserts when full, even if a pop happens in the same cycle. There is no push on a full queue.
  - A push into an empty queue becomes visible the next cycle. There is no fall-through to `ir`.
- Issue FSM, three states:
  - IDLE: if `!empty && w`, load `ir` from the head, pop, set `s`, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: hold `s=1`. When `w==0` is sampled, clear `s` and go to EXEC.
  - EXEC: hold `ir`. When `w==1` is sampled, increment `issued` and go to IDLE.
- `busy` = state ≠ IDLE.
- `ir` changes only on the IDLE→LAUNCH transition. Decoded outputs therefore stay stable for the whole controller execution.
- Register number selection (combinational from `ir` and `nsel`):
  - Rn = `ir[10:8]`, Rd = `ir[7:5]`, Rm = `ir[2:0]`.
  - `nsel` not one-hot → `readnum = 3'b000`.
- Sign extension: replicate `ir[7]` (for `sximm8`) and `ir[4]` (for `sximm5`) into the upper bits.
- Reset (`reset_n==0` at an edge), from any state including mid-LAUNCH or EXEC:
  - state=IDLE, `s=0`, `ir=16'h0000`, pointers=0 (queue empty), `issued=0`.
  - Queued and in-flight instructions are discarded.
  - Post-reset outputs: `in_ready=1`, `empty=1`, `busy=0`, `opcode=0`, `op=0`, `sximm8=0`, `sximm5=0`.

## Timing
- Edge 0: head present in IDLE and `w=1`.
- Edge 1: `s=1` and `ir` is valid.
- The controller leaves WAIT at the next edge and lowers `w` one edge later. `s` stays high until `w=0` is sampled, so `s` is high for at least 2 cycles.
- Minimum spacing between launches: execution time + 1 IDLE cycle.
- Push and pop may occur in the same cycle on a non-full, non-empty queue; occupancy is then unchanged.
- `w` low while in IDLE → no issue; no timeout.

## Structure
- Package `cpu_pkg`:
  - `nsel` encodings `RN`, `RD`, `RM`.
  - Opcode constants `OPC_ALU=3'b101`, `OPC_MOV=3'b110`.
  - Enum `issue_state_t {IDLE, LAUNCH, EXEC}`.
- Sub-module `instr_decoder`: purely combinational; `ir` + `nsel` → `opcode`, `op`, `shift`, `sximm8`, `sximm5`, `readnum`, `writenum`.
- Queue and FSM live in the top module.

## Test plan
- Push `16'hD205` (MOV R2,#5) with `w=1` → `s` rises 2 edges after push; `opcode=3'b110`, `op=2'b10`, `sximm8=16'h0005`; `nsel=3'b100` gives `readnum=2`.
- Push `16'hD0FF` → `sximm8=16'hFFFF`, `sximm5=16'hFFFF`.
- Push `16'hA223` (ADD R1,R2,R3) with a controller model whose `w` drops 2 cycles after `s` and rises 4 cycles later:
  - `nsel=100/010/001` gives `readnum=2/1/3`.
  - `ir` is stable throughout.
  - `issued` goes 0→1 on the return of `w`.
- Push 5 words with `DEPTH=4` and `w=0` → `in_ready=0` after 4; the 5th is held by the producer; `empty=0`.
- Push 3 words, run with the model controller → issued in FIFO order; `issued=3`; `empty=1`.
- Drop `reset_n` during LAUNCH with 2 words queued → next edge `s=0`, `busy=0`, `empty=1`, `issued=0`, `ir=0`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction issue queue and its decoder.
package cpu_pkg;

  localparam logic [2:0] RN = 3'b100;
  localparam logic [2:0] RD = 3'b010;
  localparam logic [2:0] RM = 3'b001;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    EXEC
  } issue_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the held instruction into controller/datapath fields.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [2:0]  nsel_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [1:0]  shift_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o,
  output logic [2:0]  readnum_o,
  output logic [2:0]  writenum_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign shift_o  = ir_i[4:3];
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  always_comb begin
    readnum_o = 3'b000;
    case (nsel_i)
      RN:      readnum_o = ir_i[10:8];
      RD:      readnum_o = ir_i[7:5];
      RM:      readnum_o = ir_i[2:0];
      default: readnum_o = 3'b000;
    endcase
  end

  assign writenum_o = readnum_o;

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction FIFO feeding the FSM controller one instruction at a time via the s/w handshake;
// the issued instruction is held in ir until the controller returns to WAIT.
module instr_issue_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        w,
  input  logic [2:0]  nsel,
  output logic        s,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        busy,
  output logic        empty,
  output logic [7:0]  issued
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  logic [15:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  issue_state_t    state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      issued_q, issued_d;

  logic full;
  logic push;
  logic pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    issued_d = issued_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && w) begin
          pop     = 1'b1;
          ir_d    = mem_q[rd_ptr_q[AW-1:0]];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!w) state_d = EXEC;
      end
      EXEC: begin
        if (w) begin
          issued_d = issued_q + 8'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ir_q     <= 16'h0000;
      issued_q <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      issued_q <= issued_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_instr;
  end

  assign s      = (state_q == LAUNCH);
  assign busy   = (state_q != IDLE);
  assign issued = issued_q;

  instr_decoder u_decoder (
    .ir_i       (ir_q),
    .nsel_i     (nsel),
    .opcode_o   (opcode),
    .op_o       (op),
    .shift_o    (shift),
    .sximm8_o   (sximm8),
    .sximm5_o   (sximm5),
    .readnum_o  (readnum),
    .writenum_o (writenum)
  );

endmodule
